jtag_tap_target_core: RTL and testbench

Parametrised JTAG TAP target: a full 16-state TAP controller with a configurable-width instruction register and three selectable data registers (bypass, user-defined, boundary-scan). It is the synthesizable DUT-side counterpart to the AVIP master agent. It generalises the fixed 3/4/5-bit instruction and 8–32-bit vector configuration into compile-time parameters. Behaviour added beyond the configuration set: capture/update semantics, pause/exit paths and unknown-opcode fallback to bypass.

---
 rtl/jtag_tap_target_core_if.sv | 10 +
 rtl/jtag_tap_target_core.sv | 141 ++++++++++++++
 tb/tb_jtag_tap_target_core.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_target_core_if.sv
// Serial JTAG pin bundle between a TAP driver (master) and the TAP target (slave).
interface jtag_tap_target_core_if;
  logic jtagTms;
  logic jtagTdi;
  logic jtagTdo;
  logic jtagTdoEn;

  modport master (output jtagTms, output jtagTdi, input jtagTdo, input jtagTdoEn);
  modport slave  (input jtagTms, input jtagTdi, output jtagTdo, output jtagTdoEn);
endinterface

// File: rtl/jtag_tap_target_core.sv
// IEEE 1149.1 TAP target: 16-state controller, parametrised IR and
// bypass / user / boundary-scan data registers with capture-shift-update stages.
module jtag_tap_target_core #(
  parameter int unsigned IR_WIDTH      = 5,
  parameter int unsigned USER_DR_WIDTH = 32,
  parameter int unsigned BSR_WIDTH     = 16,
  parameter int unsigned BYPASS_OPCODE = 0,
  parameter int unsigned USER_OPCODE   = 1,
  parameter int unsigned BSR_OPCODE    = 6
) (
  input  logic                     jtagClk,
  input  logic                     jtagRst,
  jtag_tap_target_core_if.slave    jtag,
  output logic [3:0]               tapState,
  output logic [IR_WIDTH-1:0]      irValue,
  output logic [USER_DR_WIDTH-1:0] userDrValue,
  input  logic [BSR_WIDTH-1:0]     bsrCaptureIn,
  output logic [BSR_WIDTH-1:0]     bsrValue,
  output logic                     updateIrPulse,
  output logic                     updateDrPulse
);

  typedef enum logic [3:0] {
    stReset     = 4'd0,  stIdle      = 4'd1,  stDrScan    = 4'd2,  stIrScan    = 4'd3,
    stCaptureIr = 4'd4,  stShiftIr   = 4'd5,  stExit1Ir   = 4'd6,  stPauseIr   = 4'd7,
    stExit2Ir   = 4'd8,  stUpdateIr  = 4'd9,  stCaptureDr = 4'd10, stShiftDr   = 4'd11,
    stExit1Dr   = 4'd12, stPauseDr   = 4'd13, stExit2Dr   = 4'd14, stUpdateDr  = 4'd15
  } tapStateT;

  typedef enum logic [1:0] {drBypass, drUser, drBsr} drSelT;

  localparam logic [IR_WIDTH-1:0] bypassOp = IR_WIDTH'(BYPASS_OPCODE);
  localparam logic [IR_WIDTH-1:0] userOp   = IR_WIDTH'(USER_OPCODE);
  localparam logic [IR_WIDTH-1:0] bsrOp    = IR_WIDTH'(BSR_OPCODE);

  tapStateT                 state, nextState;
  drSelT                    drSel;
  logic [IR_WIDTH-1:0]      irShift;
  logic                     bypassReg;
  logic [USER_DR_WIDTH-1:0] userShift;
  logic [BSR_WIDTH-1:0]     bsrShift;

  assign tapState = state;

  always_comb begin
    nextState = state;
    case (state)
      stReset:     nextState = jtag.jtagTms ? stReset     : stIdle;
      stIdle:      nextState = jtag.jtagTms ? stDrScan    : stIdle;
      stDrScan:    nextState = jtag.jtagTms ? stIrScan    : stCaptureDr;
      stIrScan:    nextState = jtag.jtagTms ? stReset     : stCaptureIr;
      stCaptureIr: nextState = jtag.jtagTms ? stExit1Ir   : stShiftIr;
      stShiftIr:   nextState = jtag.jtagTms ? stExit1Ir   : stShiftIr;
      stExit1Ir:   nextState = jtag.jtagTms ? stUpdateIr  : stPauseIr;
      stPauseIr:   nextState = jtag.jtagTms ? stExit2Ir   : stPauseIr;
      stExit2Ir:   nextState = jtag.jtagTms ? stUpdateIr  : stShiftIr;
      stUpdateIr:  nextState = jtag.jtagTms ? stDrScan    : stIdle;
      stCaptureDr: nextState = jtag.jtagTms ? stExit1Dr   : stShiftDr;
      stShiftDr:   nextState = jtag.jtagTms ? stExit1Dr   : stShiftDr;
      stExit1Dr:   nextState = jtag.jtagTms ? stUpdateDr  : stPauseDr;
      stPauseDr:   nextState = jtag.jtagTms ? stExit2Dr   : stPauseDr;
      stExit2Dr:   nextState = jtag.jtagTms ? stUpdateDr  : stShiftDr;
      stUpdateDr:  nextState = jtag.jtagTms ? stDrScan    : stIdle;
      default:     nextState = stReset;
    endcase
  end

  // Unknown opcodes fall back to bypass so the chain length stays defined.
  always_comb begin
    drSel = drBypass;
    if (irValue == userOp)     drSel = drUser;
    else if (irValue == bsrOp) drSel = drBsr;
  end

  always_comb begin
    jtag.jtagTdo   = 1'b0;
    jtag.jtagTdoEn = 1'b0;
    case (state)
      stShiftIr: begin
        jtag.jtagTdo   = irShift[0];
        jtag.jtagTdoEn = 1'b1;
      end
      stShiftDr: begin
        jtag.jtagTdoEn = 1'b1;
        case (drSel)
          drUser:  jtag.jtagTdo = userShift[0];
          drBsr:   jtag.jtagTdo = bsrShift[0];
          default: jtag.jtagTdo = bypassReg;
        endcase
      end
      default: ;
    endcase
  end

  // Shifts are written as a widened right shift so width-1 registers need no slicing.
  always_ff @(posedge jtagClk) begin
    if (jtagRst) begin
      state         <= stReset;
      irShift       <= '0;
      bypassReg     <= 1'b0;
      userShift     <= '0;
      bsrShift      <= '0;
      irValue       <= bypassOp;
      userDrValue   <= '0;
      bsrValue      <= '0;
      updateIrPulse <= 1'b0;
      updateDrPulse <= 1'b0;
    end else begin
      state         <= nextState;
      updateIrPulse <= (state == stUpdateIr);
      updateDrPulse <= (state == stUpdateDr);
      case (state)
        stReset:     irValue <= bypassOp;
        stCaptureIr: irShift <= IR_WIDTH'(2'b01);
        stShiftIr:   irShift <= IR_WIDTH'({jtag.jtagTdi, irShift} >> 1);
        stUpdateIr:  irValue <= irShift;
        stCaptureDr: begin
          bypassReg <= 1'b0;
          userShift <= userDrValue;
          bsrShift  <= bsrCaptureIn;
        end
        stShiftDr: begin
          case (drSel)
            drUser:  userShift <= USER_DR_WIDTH'({jtag.jtagTdi, userShift} >> 1);
            drBsr:   bsrShift  <= BSR_WIDTH'({jtag.jtagTdi, bsrShift} >> 1);
            default: bypassReg <= jtag.jtagTdi;
          endcase
        end
        stUpdateDr: begin
          case (drSel)
            drUser:  userDrValue <= userShift;
            drBsr:   bsrValue    <= bsrShift;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_target_core.sv
// Directed bench for jtag_tap_target_core: state walk, IR/DR scans, pause, bypass, BSR and reset.
module tb_jtag_tap_target_core;

  logic        clk;
  logic        jtagRst;
  logic [3:0]  tapState;
  logic [4:0]  irValue;
  logic [31:0] userDrValue;
  logic [15:0] bsrCaptureIn;
  logic [15:0] bsrValue;
  logic        updateIrPulse;
  logic        updateDrPulse;
  logic        lastTdo;
  int          passCnt;
  int          checkCnt;

  jtag_tap_target_core_if jtag ();

  jtag_tap_target_core #(
    .IR_WIDTH      (5),
    .USER_DR_WIDTH (32),
    .BSR_WIDTH     (16),
    .BYPASS_OPCODE (0),
    .USER_OPCODE   (1),
    .BSR_OPCODE    (6)
  ) dut (
    .jtagClk       (clk),
    .jtagRst       (jtagRst),
    .jtag          (jtag.slave),
    .tapState      (tapState),
    .irValue       (irValue),
    .userDrValue   (userDrValue),
    .bsrCaptureIn  (bsrCaptureIn),
    .bsrValue      (bsrValue),
    .updateIrPulse (updateIrPulse),
    .updateDrPulse (updateDrPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // TDO is sampled before the edge, i.e. the bit that edge shifts out.
  task automatic step(input logic tms, input logic tdi);
    jtag.jtagTms = tms;
    jtag.jtagTdi = tdi;
    #1;
    lastTdo = jtag.jtagTdo;
    @(posedge clk);
    #1;
  endtask

  task automatic loadIr(input logic [63:0] val, input int n, output logic [63:0] outBits);
    outBits = '0;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, val[i]);
      outBits[i] = lastTdo;
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic scanDr(input logic [63:0] val, input int n, output logic [63:0] outBits);
    outBits = '0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, val[i]);
      outBits[i] = lastTdo;
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  int          pathLen [16];
  logic [7:0]  pathBits[16];

  initial begin
    logic [63:0] outBits;
    logic [3:0]  bypassOut;
    logic [7:0]  partial;

    passCnt = 0;
    checkCnt = 0;
    jtag.jtagTms = 1'b1;
    jtag.jtagTdi = 1'b0;
    bsrCaptureIn = 16'h0;
    jtagRst = 1'b1;

    // TMS paths from Reset, bit i applied on edge i
    pathLen = '{0, 1, 2, 3, 4, 5, 5, 6, 7, 6, 3, 4, 4, 5, 6, 5};
    pathBits[0]  = 8'b0;       pathBits[1]  = 8'b0;       pathBits[2]  = 8'b10;
    pathBits[3]  = 8'b110;     pathBits[4]  = 8'b0110;    pathBits[5]  = 8'b00110;
    pathBits[6]  = 8'b10110;   pathBits[7]  = 8'b010110;  pathBits[8]  = 8'b1010110;
    pathBits[9]  = 8'b110110;  pathBits[10] = 8'b010;     pathBits[11] = 8'b0010;
    pathBits[12] = 8'b1010;    pathBits[13] = 8'b01010;   pathBits[14] = 8'b101010;
    pathBits[15] = 8'b11010;

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checkVal("rstState", tapState, 0);
    checkVal("rstIr", irValue, 0);
    checkVal("rstUser", userDrValue, 0);
    checkVal("rstBsr", bsrValue, 0);
    checkVal("rstTdoEn", jtag.jtagTdoEn, 0);
    checkVal("rstPulses", {updateIrPulse, updateDrPulse}, 0);
    jtagRst = 1'b0;

    for (int s = 0; s < 16; s++) begin
      for (int b = 0; b < pathLen[s]; b++) step(pathBits[s][b], 1'b0);
      checkVal($sformatf("walk%0d", s), tapState, s);
      repeat (5) step(1'b1, 1'b0);
      checkVal($sformatf("tms5from%0d", s), tapState, 0);
    end
    checkVal("irAfterWalk", irValue, 0);

    step(1'b0, 1'b0);
    loadIr(64'h01, 5, outBits);
    checkVal("irCaptureTdo", outBits[4:0], 5'b00001);
    checkVal("irLoad", irValue, 1);
    checkVal("irPulseHi", updateIrPulse, 1);
    checkVal("drPulseLoIr", updateDrPulse, 0);
    step(1'b0, 1'b0);
    checkVal("irPulseLo", updateIrPulse, 0);

    scanDr(64'hA5A5_1234, 32, outBits);
    checkVal("userWrite", userDrValue, 32'hA5A5_1234);
    checkVal("userCapture0", outBits[31:0], 0);
    checkVal("drPulseHi", updateDrPulse, 1);
    step(1'b0, 1'b0);
    checkVal("drPulseLo", updateDrPulse, 0);
    scanDr(64'h0, 32, outBits);
    checkVal("userReadback", outBits[31:0], 32'hA5A5_1234);
    checkVal("userCleared", userDrValue, 0);

    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    checkVal("shiftDrTdoEn", jtag.jtagTdoEn, 1);
    for (int i = 0; i < 16; i++) step(i == 15, 16'h5678 >> i);
    checkVal("exit1Dr", tapState, 12);
    repeat (10) step(1'b0, 1'b0);
    checkVal("pauseDr", tapState, 13);
    checkVal("pauseTdoEn", jtag.jtagTdoEn, 0);
    checkVal("pauseHold", userDrValue, 0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    checkVal("reShiftDr", tapState, 11);
    for (int i = 0; i < 16; i++) step(i == 15, 16'h9ABC >> i);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    checkVal("pauseConcat", userDrValue, 32'h9ABC_5678);

    loadIr(64'h1F, 5, outBits);
    checkVal("irUnknown", irValue, 5'b11111);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); bypassOut[0] = lastTdo;
    step(1'b0, 1'b0); bypassOut[1] = lastTdo;
    step(1'b0, 1'b1); bypassOut[2] = lastTdo;
    step(1'b1, 1'b1); bypassOut[3] = lastTdo;
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    checkVal("bypassTdo", bypassOut, 4'b1010);
    checkVal("bypassPulse", updateDrPulse, 1);
    checkVal("bypassUserKeep", userDrValue, 32'h9ABC_5678);

    bsrCaptureIn = 16'hBEEF;
    loadIr(64'h06, 5, outBits);
    checkVal("irBsr", irValue, 6);
    scanDr(64'h1357, 16, outBits);
    checkVal("bsrCaptureTdo", outBits[15:0], 16'hBEEF);
    checkVal("bsrWrite", bsrValue, 16'h1357);
    checkVal("bsrUserKeep", userDrValue, 32'h9ABC_5678);

    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      partial[i] = lastTdo;
    end
    checkVal("bsrPartialTdo", partial, 8'hEF);
    jtagRst = 1'b1;
    step(1'b0, 1'b0);
    checkVal("midRstState", tapState, 0);
    checkVal("midRstBsr", bsrValue, 0);
    checkVal("midRstUser", userDrValue, 0);
    checkVal("midRstIr", irValue, 0);
    checkVal("midRstDrPulse", updateDrPulse, 0);
    checkVal("midRstTdoEn", jtag.jtagTdoEn, 0);
    jtagRst = 1'b0;
    step(1'b1, 1'b0);
    checkVal("postRstDrPulse", updateDrPulse, 0);
    checkVal("postRstState", tapState, 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
